// File: rtl/sha256_padder_if.sv
// sha256_padder_if
//   Handshake bundle between a word source, the padder and the block sink.
//   Input side : in_valid / in_ready / in_data[31:0] / in_last / in_bytes[1:0]
//   Output side: blk_valid / blk_ready / blk_data[511:0] / blk_last
//   modport slave  : the padder (consumes words, produces blocks)
//   modport master : the environment (produces words, consumes blocks)
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder
//   Collects a byte message arriving as big-endian 32-bit words, appends the
//   SHA-256 padding (0x80 marker, zero fill, 64-bit bit length) and presents
//   complete 512-bit blocks to the compression core.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     bus.slave  word input (in_*) and block output (blk_*) handshakes
//   Parameter LEN_W: width of the bit-length field (64 for SHA-256).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | accepting message words into the buffer
//   PAD   | writing marker / zero / length words, one per cycle
//   OUT   | block presented on blk_data, waiting for blk_ready
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  sha256_padder_if.slave  bus
);

  localparam int BC_W = LEN_W - 3;

  typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

  state_t            state;
  logic [31:0]       word_q [16];
  logic [3:0]        wcnt;
  logic [BC_W-1:0]   bcnt;
  logic              pend;
  logic              fits;
  logic              msg_end;   // last word accepted, length not yet emitted
  logic              in_ready_q;
  logic              blk_valid_q;
  logic              blk_last_q;

  logic [2:0]        nbytes;
  logic [31:0]       last_word;
  logic [4:0]        n_next;
  logic [LEN_W-1:0]  len;
  logic [31:0]       pad_word;
  logic [511:0]      blk_data_w;

  always_comb begin
    nbytes = (bus.in_bytes == 2'd0) ? 3'd4 : {1'b0, bus.in_bytes};
  end

  // Short final word: keep the valid bytes, place the marker right after them.
  always_comb begin
    last_word = bus.in_data;
    case (bus.in_bytes)
      2'd1:    last_word = {bus.in_data[31:24], 24'h800000};
      2'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      2'd3:    last_word = {bus.in_data[31:8],  8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    n_next = {1'b0, wcnt} + 5'd1;
    len    = {bcnt, 3'b000};
  end

  always_comb begin
    pad_word = 32'h0;
    if (pend)
      pad_word = 32'h8000_0000;
    else if (fits && wcnt == 4'd14)
      pad_word = len[LEN_W-1 -: 32];
    else if (fits && wcnt == 4'd15)
      pad_word = len[31:0];
  end

  always_comb begin
    blk_data_w = '0;
    for (int i = 0; i < 16; i++)
      blk_data_w[511 - 32*i -: 32] = word_q[i];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_data  = blk_data_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wcnt        <= 4'd0;
      bcnt        <= '0;
      pend        <= 1'b0;
      fits        <= 1'b0;
      msg_end     <= 1'b0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++)
        word_q[i] <= 32'h0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            if (!bus.in_last) begin
              word_q[wcnt] <= bus.in_data;
              bcnt         <= bcnt + BC_W'(4);
              if (wcnt == 4'd15) begin
                state       <= OUT;
                in_ready_q  <= 1'b0;
                blk_valid_q <= 1'b1;
                blk_last_q  <= 1'b0;
                wcnt        <= 4'd0;
              end else begin
                wcnt <= wcnt + 4'd1;
              end
            end else begin
              word_q[wcnt] <= last_word;
              bcnt         <= bcnt + BC_W'(nbytes);
              // A full last word still owes the marker to the next slot.
              pend         <= (nbytes == 3'd4);
              fits         <= ((n_next + {4'b0000, (nbytes == 3'd4)}) <= 5'd14);
              msg_end      <= 1'b1;
              in_ready_q   <= 1'b0;
              if (wcnt == 4'd15) begin
                state       <= OUT;
                blk_valid_q <= 1'b1;
                blk_last_q  <= 1'b0;
                wcnt        <= 4'd0;
              end else begin
                state <= PAD;
                wcnt  <= n_next[3:0];
              end
            end
          end
        end

        PAD: begin
          word_q[wcnt] <= pad_word;
          if (pend)
            pend <= 1'b0;
          if (wcnt == 4'd15) begin
            state       <= OUT;
            blk_valid_q <= 1'b1;
            blk_last_q  <= fits;
            wcnt        <= 4'd0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end

        OUT: begin
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            if (msg_end && !blk_last_q) begin
              // Length did not fit: build a trailing block that carries it.
              fits  <= 1'b1;
              state <= PAD;
              wcnt  <= 4'd0;
            end else begin
              state      <= FILL;
              in_ready_q <= 1'b1;
              if (blk_last_q) begin
                bcnt    <= '0;
                msg_end <= 1'b0;
              end
            end
          end
        end

        default: begin
          state      <= FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } blk_t;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  blk_t exp_q[$];

  always #5 clk = ~clk;

  sha256_padder_if bus();

  sha256_padder #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Byte-level reference padding: marker, zero fill to 56 mod 64, 8-byte length.
  function automatic void model(input byte_q_t m);
    byte_q_t     p;
    logic [63:0] bits;
    blk_t        b;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    for (int base = 0; base < p.size(); base += 64) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data[511 - 8*j -: 8] = p[base + j];
      b.last = (base + 64 == p.size());
      exp_q.push_back(b);
    end
  endfunction

  function automatic byte_q_t make_msg(input int n, input int seed_mode);
    byte_q_t m;
    for (int i = 0; i < n; i++)
      m.push_back(seed_mode == 0 ? 8'(i + 1) : 8'($urandom_range(0, 255)));
    return m;
  endfunction

  // Streams one message, services blocks against the scoreboard. lat is the
  // cycle distance from the last word's accept cycle to the first blk_valid.
  task automatic send_msg(input byte_q_t m, input bit use_model, input int stall,
                          output int lat);
    int          n, nw, idx, cyc, acc_cyc, stall_left;
    bit          holding;
    logic [511:0] held;
    logic        held_last;
    logic [31:0] w;
    blk_t        e;
    n = m.size();
    nw = (n + 3) / 4;
    idx = 0; cyc = 0; acc_cyc = -1; stall_left = stall; holding = 0;
    held = '0; held_last = 1'b0;
    lat = -1;
    if (use_model) model(m);
    while ((idx < nw || exp_q.size() > 0) && cyc < 3000) begin
      if (idx < nw) begin
        for (int j = 0; j < 4; j++)
          w[31 - 8*j -: 8] = (4*idx + j < n) ? m[4*idx + j] : 8'hA5;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = (idx == nw - 1);
        bus.in_bytes = 2'(n % 4);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
      if (bus.blk_valid && stall_left > 0) begin
        bus.blk_ready = 1'b0;
        if (!holding) begin
          held = bus.blk_data; held_last = bus.blk_last; holding = 1;
        end else begin
          checks++;
          if (bus.blk_data !== held || bus.blk_last !== held_last || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_stable: data=%h last=%b in_ready=%b, required data=%h last=%b in_ready=0",
                     bus.blk_data, bus.blk_last, bus.in_ready, held, held_last);
          end
        end
        stall_left--;
      end else begin
        bus.blk_ready = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (idx == nw - 1) acc_cyc = cyc;
        idx++;
      end
      if (bus.blk_valid && lat < 0 && acc_cyc >= 0) lat = cyc - acc_cyc;
      if (bus.blk_valid && bus.blk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got data=%h last=%b, required no block", bus.blk_data, bus.blk_last);
        end else begin
          e = exp_q.pop_front();
          if (bus.blk_data !== e.data || bus.blk_last !== e.last) begin
            errors++;
            $display("FAIL block: got data=%h last=%b, required data=%h last=%b",
                     bus.blk_data, bus.blk_last, e.data, e.last);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.blk_ready = 1'b1;
    checks++;
    if (idx < nw || exp_q.size() != 0) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d of %0d words, %0d blocks outstanding, required all done",
               idx, nw, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_msg: blk_valid=%b in_ready=%b, required 0 and 1", bus.blk_valid, bus.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.blk_valid !== 1'b0 || bus.blk_last !== 1'b0 || bus.blk_data !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%b blk_valid=%b blk_last=%b data_nonzero=%b, required 1 0 0 0",
               tag, bus.in_ready, bus.blk_valid, bus.blk_last, (bus.blk_data != '0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_values");
    #11 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    byte_q_t m;
    blk_t    b;
    int      lat;
    m = {8'h61, 8'h62, 8'h63};
    b.data = '0;
    b.data[511:480] = 32'h61626380;
    b.data[31:0]    = 32'h00000018;
    b.last = 1'b1;
    exp_q.push_back(b);
    send_msg(m, 1'b0, 0, lat);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL abc_latency: got %0d, required 16", lat);
    end
  endtask

  task automatic test_len(input int n, input int exp_lat);
    int lat;
    send_msg(make_msg(n, 0), 1'b1, 0, lat);
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL latency_len%0d: got %0d, required %0d", n, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_msg(make_msg(72, 1), 1'b1, 70, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    send_msg(make_msg(40, 1), 1'b1, 0, lat);
    send_msg(make_msg(3, 1), 1'b1, 0, lat);
    send_msg(make_msg(60, 1), 1'b1, 0, lat);
  endtask

  task automatic test_reset_mid_pad();
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h61626300;
    bus.in_last  = 1'b1;
    bus.in_bytes = 2'd3;
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_pad_state: in_ready=%b blk_valid=%b, required 0 0", bus.in_ready, bus.blk_valid);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_pad");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send_msg(make_msg(3, 0), 1'b1, 0, lat);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d, required 16", lat);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 8; t++)
      send_msg(make_msg($urandom_range(1, 140), 1), 1'b1, 0, lat);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = 2'd0;
    bus.blk_ready = 1'b1;
    test_reset();
    test_abc();
    test_len(55, 3);
    test_len(56, 3);
    test_len(64, 1);
    test_len(1, 16);
    test_len(2, -1);
    test_len(63, 1);
    test_len(128, -1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_pad();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
